seq_serializer: RTL and testbench
=================================

// Module: seq_serializer
// PURPOSE
//   Upstream feeder for the bit-serial parity checker. Accepts a WIDTH-bit parallel
//   sequence word through a load/ready handshake and shifts it out one bit per clock
//   with bit_valid/last framing. Emits a one-cycle done pulse per frame, so the
//   checker's result can be sampled and the next word loaded.
// PARAMETERS
//   WIDTH       3   data bits per frame; legal range >=1
//   MSB_FIRST   1   1: shift out data_in[WIDTH-1] first; 0: shift out data_in[0] first
//   ODD_PARITY  0   appended-bit sense, used only under SEQ_SER_PARITY_EN; 0 even, 1 odd
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   reset      in   1      asynchronous, active-low reset (0 = reset)
//   load       in   1      request to accept data_in
//   data_in    in   WIDTH  parallel sequence word
//   ready      out  1      block is idle and can accept a load
//   bit_out    out  1      current serial bit; 0 when bit_valid=0
//   bit_valid  out  1      bit_out carries a frame bit this cycle
//   last       out  1      final bit of the frame; only with bit_valid=1
//   done       out  1      one-cycle pulse in the cycle after last
// BEHAVIOUR
//   - Reset (reset=0): immediate, independent of clk. Clears state to IDLE and
//     shift register, bit counter and parity accumulator to 0.
//     Outputs during reset: ready=1, bit_out=0, bit_valid=0, last=0, done=0.
//   - All outputs are decoded from registered state only. No combinational path
//     exists from load or data_in to any output.
//   - FSM states:
//     IDLE  -> SHIFT on a clk edge with load=1 (ready=1 in IDLE): capture data_in,
//              count=0, parity accumulator=0.
//     SHIFT -> bit_valid=1. Each edge: shift toward the output end, count+1,
//              accumulator ^= bit_out.
//              At count==WIDTH-1: last=1 (no parity option), next state DONE (or PAR).
//     PAR   -> (option only) bit_out = accumulator ^ ODD_PARITY, bit_valid=1, last=1;
//              next state DONE.
//     DONE  -> done=1 for exactly one cycle, ready=0; next state IDLE.
//   - Latency: load accepted at edge N. First bit is valid from N until edge N+1.
//     Last data bit is valid in cycle N+WIDTH-1 to N+WIDTH.
//   - Frame period: WIDTH+2 cycles without the option, WIDTH+3 with it.
//   - load while ready=0 (SHIFT/PAR/DONE): ignored. In-flight frame is not disturbed.
//     data_in changes mid-frame have no effect.
//   - WIDTH=1: single SHIFT cycle with bit_valid=1 and last=1 together.
//   - Reset asserted mid-frame: frame is aborted, with no done pulse. After release,
//     the block is in IDLE and the first load is accepted normally.
//   - count width is clog2(WIDTH)+1. Count never wraps within a frame.
// CONFIGURATION
//   SEQ_SER_PARITY_EN defined: PAR state is compiled in. One extra bit per frame
//     carries the even/odd parity of the data bits. last moves to the PAR cycle.
//   SEQ_SER_PARITY_EN undefined: no PAR state and no accumulator logic. Frame is
//     WIDTH data bits only. ODD_PARITY has no effect.
// TESTING  (WIDTH=3 unless noted)
//   1. Release reset; load=1 with data_in=3'b101, MSB_FIRST=1 -> bit_out 1,0,1
//      on 3 bit_valid cycles. last=1 on the 3rd. done=1 the next cycle. ready=1 after.
//   2. SEQ_SER_PARITY_EN, ODD_PARITY=0, data_in=3'b110 -> bits 1,1,0 then parity 0.
//      last=1 on the 4th bit. With ODD_PARITY=1 the parity bit is 1.
//   3. During frame 3'b011, hold load=1 with data_in=3'b111 -> stream stays 0,1,1.
//      3'b111 is accepted only on the first edge where ready=1.
//   4. Pull reset low asynchronously during the 2nd bit of 3'b101 ->
//      bit_valid/last/done drop to 0 immediately; ready=1; no done pulse.
//      After release, a load of 3'b010 streams 0,1,0.
//   5. MSB_FIRST=0, data_in=3'b100 -> bits 0,0,1. WIDTH=1 with data_in=1 ->
//      one cycle with bit_out=1, bit_valid=1, last=1.
//   6. Back-to-back loads 3'b000..3'b111 with load held high -> frames 5 cycles apart.
//      Serial XOR of each frame matches ^data_in. Exactly 8 done pulses.

Source files
------------

// File: rtl/seq_serializer.sv
`default_nettype none
// seq_serializer: accepts a WIDTH-bit word on load/ready and shifts it out one bit per clock
// with bit_valid/last framing and a one-cycle done pulse. Optional parity bit: SEQ_SER_PARITY_EN.
module seq_serializer #(
  parameter int WIDTH      = 3,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             last,
  output logic             done
);

  localparam int            CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  // Bit 1 selects shift direction, bit 0 is the appended-parity sense.
  localparam logic [1:0]    CFG      = {MSB_FIRST, ODD_PARITY};

`ifdef SEQ_SER_PARITY_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_PAR   = 2'd2,
    S_DONE  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd3
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    count_q, count_d;
`ifdef SEQ_SER_PARITY_EN
  logic             acc_q, acc_d;
`endif

  logic shift_head;
  assign shift_head = CFG[1] ? shreg_q[WIDTH-1] : shreg_q[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      count_q <= '0;
`ifdef SEQ_SER_PARITY_EN
      acc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      count_q <= count_d;
`ifdef SEQ_SER_PARITY_EN
      acc_q   <= acc_d;
`endif
    end
  end

  // Outputs depend on state_q and datapath registers only; load/data_in affect next state alone.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    count_d   = count_q;
`ifdef SEQ_SER_PARITY_EN
    acc_d     = acc_q;
`endif
    ready     = 1'b0;
    bit_out   = 1'b0;
    bit_valid = 1'b0;
    last      = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (load) begin
          state_d = S_SHIFT;
          shreg_d = data_in;
          count_d = '0;
`ifdef SEQ_SER_PARITY_EN
          acc_d   = 1'b0;
`endif
        end
      end

      S_SHIFT: begin
        bit_valid = 1'b1;
        bit_out   = shift_head;
        shreg_d   = CFG[1] ? (shreg_q << 1) : (shreg_q >> 1);
        count_d   = count_q + CW'(1);
`ifdef SEQ_SER_PARITY_EN
        acc_d     = acc_q ^ shift_head;
        if (count_q == LAST_IDX) begin
          state_d = S_PAR;
        end
`else
        if (count_q == LAST_IDX) begin
          last    = 1'b1;
          state_d = S_DONE;
        end
`endif
      end

`ifdef SEQ_SER_PARITY_EN
      S_PAR: begin
        bit_valid = 1'b1;
        bit_out   = acc_q ^ CFG[0];
        last      = 1'b1;
        state_d   = S_DONE;
      end
`endif

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_serializer.sv
`default_nettype none
// tb_seq_serializer: scoreboard bench; three instances cover MSB-first W=3, LSB-first W=3 and W=1.
module tb_seq_serializer;

  localparam int W = 3;
`ifdef SEQ_SER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int PERIOD = W + 2 + (PAR ? 1 : 0);

  typedef logic [1:0] ent_t;  // {bit_out, last}

  logic       clk = 1'b0;
  logic       reset;
  logic       load0, load1, load2;
  logic [2:0] data0, data1;
  logic [0:0] data2;
  wire  [2:0] rdy, bo, bv, lst, dn;

  int   checks = 0;
  int   fails  = 0;
  ent_t exp_q[3][$];
  int   n_done[3];
  bit   last_prev[3];
  bit   chk_period = 1'b0;
  bit   have_prev  = 1'b0;
  int   prev_done_cyc = 0;
  int   cyc = 0;
  ent_t e;

  always #5 clk = ~clk;

  seq_serializer #(.WIDTH(3), .MSB_FIRST(1'b1), .ODD_PARITY(1'b0)) u_dut (
    .clk(clk), .reset(reset), .load(load0), .data_in(data0),
    .ready(rdy[0]), .bit_out(bo[0]), .bit_valid(bv[0]), .last(lst[0]), .done(dn[0])
  );

  seq_serializer #(.WIDTH(3), .MSB_FIRST(1'b0), .ODD_PARITY(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .load(load1), .data_in(data1),
    .ready(rdy[1]), .bit_out(bo[1]), .bit_valid(bv[1]), .last(lst[1]), .done(dn[1])
  );

  seq_serializer #(.WIDTH(1), .MSB_FIRST(1'b1), .ODD_PARITY(1'b0)) u_w1 (
    .clk(clk), .reset(reset), .load(load2), .data_in(data2),
    .ready(rdy[2]), .bit_out(bo[2]), .bit_valid(bv[2]), .last(lst[2]), .done(dn[2])
  );

  function automatic void push_frame(input int k, input logic [7:0] d, input int w, input bit msb);
    logic acc = 1'b0;
    logic b;
    for (int i = 0; i < w; i++) begin
      b = msb ? d[w-1-i] : d[i];
      acc ^= b;
      exp_q[k].push_back({b, (i == w - 1) && !PAR});
    end
    if (PAR) exp_q[k].push_back({acc, 1'b1});
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic send(input int k, input logic [7:0] d, input int w, input bit msb);
    int t = 0;
    @(negedge clk);
    case (k)
      0: begin load0 = 1'b1; data0 = d[2:0]; end
      1: begin load1 = 1'b1; data1 = d[2:0]; end
      default: begin load2 = 1'b1; data2 = d[0:0]; end
    endcase
    while (!rdy[k] && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!rdy[k]) begin
      fails++;
      $display("FAIL send_timeout dut%0d: ready=%b, expected 1 within 50 cycles", k, rdy[k]);
    end else begin
      push_frame(k, d, w, msb);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int k);
    int t = 0;
    while ((exp_q[k].size() != 0 || !rdy[k]) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("drain_dut%0d", k), exp_q[k].size(), 0);
  endtask

  // Monitor: pops expected {bit,last} on every bit_valid cycle and checks framing.
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        checks++;
        if (bv[k]) begin
          if (exp_q[k].size() == 0) begin
            fails++;
            $display("FAIL unexpected_bit dut%0d: got bit=%b last=%b, expected no bit", k, bo[k], lst[k]);
          end else begin
            e = exp_q[k].pop_front();
            if ({bo[k], lst[k]} !== e) begin
              fails++;
              $display("FAIL bit dut%0d: got bit=%b last=%b, expected bit=%b last=%b",
                       k, bo[k], lst[k], e[1], e[0]);
            end
          end
        end else if (bo[k] !== 1'b0 || lst[k] !== 1'b0) begin
          fails++;
          $display("FAIL idle_out dut%0d: got bit=%b last=%b, expected 0 0", k, bo[k], lst[k]);
        end
        if (dn[k]) begin
          n_done[k]++;
          checks++;
          if (!last_prev[k]) begin
            fails++;
            $display("FAIL done_after_last dut%0d: got done without last, expected last previous cycle", k);
          end
          if (k == 0 && chk_period) begin
            if (have_prev) begin
              checks++;
              if (cyc - prev_done_cyc != PERIOD) begin
                fails++;
                $display("FAIL frame_period: got %0d, expected %0d", cyc - prev_done_cyc, PERIOD);
              end
            end
            prev_done_cyc = cyc;
            have_prev     = 1'b1;
          end
        end
        last_prev[k] = bv[k] & lst[k];
      end else begin
        last_prev[k] = 1'b0;
      end
    end
  end

  initial begin
    int snap;
    reset = 1'b0;
    load0 = 1'b0; load1 = 1'b0; load2 = 1'b0;
    data0 = '0;   data1 = '0;   data2 = '0;
    for (int k = 0; k < 3; k++) n_done[k] = 0;

    repeat (2) @(negedge clk);
    chk("rst_ready", {29'd0, rdy}, 32'h7);
    chk("rst_bit_valid", {29'd0, bv}, 32'h0);
    chk("rst_bit_out", {29'd0, bo}, 32'h0);
    chk("rst_last", {29'd0, lst}, 32'h0);
    chk("rst_done", {29'd0, dn}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Basic MSB-first frame
    send(0, 8'b101, 3, 1'b1);
    load0 = 1'b0;
    wait_idle(0);
    chk("ready_after_frame", {31'd0, rdy[0]}, 32'h1);
    chk("done_count_1", n_done[0], 1);

    send(0, 8'b110, 3, 1'b1);
    load0 = 1'b0;
    wait_idle(0);

    // load held high with new data during an in-flight frame
    send(0, 8'b011, 3, 1'b1);
    send(0, 8'b111, 3, 1'b1);
    load0 = 1'b0;
    wait_idle(0);
    chk("done_count_hold", n_done[0], 4);

    // Asynchronous reset during the second bit aborts the frame
    send(0, 8'b101, 3, 1'b1);
    load0 = 1'b0;
    snap  = n_done[0];
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_bit_valid", {31'd0, bv[0]}, 32'h0);
    chk("abort_last", {31'd0, lst[0]}, 32'h0);
    chk("abort_done", {31'd0, dn[0]}, 32'h0);
    chk("abort_ready", {31'd0, rdy[0]}, 32'h1);
    exp_q[0].delete();
    @(posedge clk);
    #2;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_no_done", n_done[0], snap);
    send(0, 8'b010, 3, 1'b1);
    load0 = 1'b0;
    wait_idle(0);

    // LSB-first and single-bit instances
    send(1, 8'b100, 3, 1'b0);
    load1 = 1'b0;
    wait_idle(1);
    chk("lsb_done_count", n_done[1], 1);
    send(2, 8'b1, 1, 1'b1);
    load2 = 1'b0;
    wait_idle(2);
    chk("w1_done_count", n_done[2], 1);

    // Back-to-back frames with load held high
    n_done[0]  = 0;
    have_prev  = 1'b0;
    chk_period = 1'b1;
    for (int d = 0; d < 8; d++) send(0, 8'(d), 3, 1'b1);
    load0 = 1'b0;
    wait_idle(0);
    chk_period = 1'b0;
    chk("btb_done_count", n_done[0], 8);

    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) chk($sformatf("final_empty_dut%0d", k), exp_q[k].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
